// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the back-end control-signal pipeline.
// Stage indices, default bundle width, mult/div counter width and the bubble value.
package ctrl_pipe_pkg;

  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  localparam int unsigned DEF_W = 17;
  localparam int unsigned CNT_W = 8;

  // A bubble is every bundle bit and the valid bit at this value.
  localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One back-end stage: W-bit control bundle plus valid bit.
// Priority: reset, flush (bubble), hold, then load source or bubble.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         flush_i,
  input  logic         hold_i,
  input  logic         load_i,
  input  logic [W-1:0] ctrl_i,
  input  logic         valid_i,
  output logic [W-1:0] ctrl_o,
  output logic         valid_o
);

  logic [W-1:0] ctrl_q, ctrl_d;
  logic         valid_q, valid_d;

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (flush_i) begin
      ctrl_d  = {W{BUBBLE_BIT}};
      valid_d = BUBBLE_BIT;
    end else if (!hold_i) begin
      // Upstream not advancing: take a bubble rather than duplicating its contents.
      ctrl_d  = load_i ? ctrl_i : {W{BUBBLE_BIT}};
      valid_d = load_i ? valid_i : BUBBLE_BIT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctrl_q  <= {W{BUBBLE_BIT}};
      valid_q <= BUBBLE_BIT;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Decode-to-writeback control bundle pipeline with per-stage stall/flush,
// plus the HI/LO mult/div occupancy counter that raises the decode stall.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned W      = DEF_W,
  parameter int unsigned STAGES = 3,
  parameter int unsigned MDLAT  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [W-1:0]          ctrlD,
  input  logic                  validD,
  input  logic                  mdstartD,
  input  logic                  mdreadD,
  input  logic                  stallD,
  input  logic [STAGES-1:0]     stall,
  input  logic [STAGES-1:0]     flush,
  output logic [STAGES*W-1:0]   ctrlQ,
  output logic [STAGES-1:0]     validQ,
  output logic                  mdbusy,
  output logic                  mddone,
  output logic                  mdstallD
);

  logic [STAGES*W-1:0] src_ctrl;
  logic [STAGES-1:0]   src_valid;
  logic [STAGES-1:0]   src_load;

  assign src_ctrl[STG_EX*W +: W] = ctrlD;
  assign src_valid[STG_EX]       = validD;
  assign src_load[STG_EX]        = ~stallD & ~mdstallD;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i > 0) begin : g_link
      assign src_ctrl[i*W +: W] = ctrlQ[(i-1)*W +: W];
      assign src_valid[i]       = validQ[i-1];
      assign src_load[i]        = ~stall[i-1];
    end

    ctrl_stage_reg #(
      .W(W)
    ) u_stage (
      .clk_i  (clk),
      .reset_i(reset),
      .flush_i(flush[i]),
      .hold_i (stall[i]),
      .load_i (src_load[i]),
      .ctrl_i (src_ctrl[i*W +: W]),
      .valid_i(src_valid[i]),
      .ctrl_o (ctrlQ[i*W +: W]),
      .valid_o(validQ[i])
    );
  end

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MDLAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             issue;

  assign mdbusy   = (cnt_q != '0);
  assign mddone   = (cnt_q == CNT_W'(1));
  assign mdstallD = validD & mdbusy & (mdstartD | mdreadD);

  // Only a mult/div that actually lands in EX this edge starts the counter.
  assign issue = validD & mdstartD & ~stallD & ~mdstallD & ~flush[STG_EX] & ~stall[STG_EX];

  always_comb begin
    cnt_d = cnt_q;
    if (issue) begin
      cnt_d = CntLoad;
    end else if (mdbusy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
